// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared FSM state encoding and address constants for the APB
//            register-file completer.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } apb_state_e;

  localparam int unsigned ID_ADDR   = 0;
  localparam int unsigned CTRL_ADDR = 1;
  localparam int unsigned MAX_WAIT  = 9;

endpackage
`default_nettype wire

// File: rtl/apb_slave_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile_if
// Purpose  : APB bus bundle between the team's APB master and the completer.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_slave_regfile_if #(
  parameter int unsigned WIDTH = 8
);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_counter
// Purpose  : Wait-state down-counter with load, decrement and zero detect.
//            Present only when APB_SLV_WAIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef APB_SLV_WAIT_EN
module apb_wait_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  // Decrement only while the access phase is live, so a dropped psel freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`endif
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : APB completer with a WIDTH-bit register bank, read-only ID at
//            address 0, control word export at address 1 and optional wait
//            states (enabled by macro APB_SLV_WAIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      WAIT_CYCLES = 2,
  parameter logic [WIDTH-1:0] ID_VALUE    = 8'hA5
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_slave_regfile_if.slave  bus,
  output logic [WIDTH-1:0]    ctrl_out,
  output logic                wr_strobe
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             write_q;
  logic [WIDTH-1:0] prdata_q;
  logic [WIDTH-1:0] prdata_d;
  logic             wr_strobe_q;
  apb_state_e       state_q;

  logic w_setup;
  logic w_access;
  logic w_cnt_zero;
  logic w_pready;
  logic w_err;
  logic w_commit;

  assign w_setup  = bus.psel & ~bus.penable;
  assign w_access = bus.psel & bus.penable;

`ifdef APB_SLV_WAIT_EN
  localparam int unsigned WAIT_LD = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;

  apb_wait_counter #(
    .CW (4)
  ) u_wait_counter (
    .clk        (pclk),
    .rst_n      (presetn),
    .load_i     (w_setup),
    .load_val_i (4'(WAIT_LD)),
    .dec_i      (w_access),
    .zero_o     (w_cnt_zero)
  );
`else
  logic [31:0] w_unused_wait;
  assign w_unused_wait = 32'(WAIT_CYCLES);
  assign w_cnt_zero    = 1'b1;
`endif

  // pready is combinational but must stay low throughout reset
  assign w_pready = presetn & w_access & w_cnt_zero;
  assign w_err    = (32'(addr_q) >= DEPTH) | (write_q & (32'(addr_q) == ID_ADDR));
  assign w_commit = w_pready & write_q & ~w_err;

  always_comb begin
    prdata_d = '0;
    if (32'(bus.paddr) == ID_ADDR) begin
      prdata_d = ID_VALUE;
    end else if (32'(bus.paddr) < DEPTH) begin
      prdata_d = mem_q[bus.paddr[AW-1:0]];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      prdata_q    <= '0;
      wr_strobe_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_strobe_q <= w_commit;
      if (w_setup) begin
        addr_q  <= bus.paddr;
        wdata_q <= bus.pwdata;
        write_q <= bus.pwrite;
        if (!bus.pwrite) begin
          prdata_q <= prdata_d;
        end
      end
      if (w_commit) begin
        mem_q[addr_q[AW-1:0]] <= wdata_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else if (!bus.psel) begin
      state_q <= IDLE;
    end else if (w_setup) begin
      state_q <= SETUP;
    end else begin
      case (state_q)
        SETUP, WAIT: state_q <= w_pready ? DONE : WAIT;
        default:     state_q <= IDLE;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = w_pready;
  assign bus.pslverr = w_pready & w_err;
  assign ctrl_out    = mem_q[CTRL_ADDR];
  assign wr_strobe   = wr_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regfile
// Purpose  : Scoreboard bench for apb_slave_regfile (honours APB_SLV_WAIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned WC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] ctrl_out;
  logic         wr_strobe;

  always #5 clk = ~clk;

  apb_slave_regfile_if #(.WIDTH(W)) bus ();

  apb_slave_regfile #(
    .WIDTH       (W),
    .DEPTH       (D),
    .WAIT_CYCLES (WC),
    .ID_VALUE    (8'hA5)
  ) dut (
    .pclk      (clk),
    .presetn   (rstn),
    .bus       (bus.slave),
    .ctrl_out  (ctrl_out),
    .wr_strobe (wr_strobe)
  );

  typedef struct {
    logic         wr;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total      = 0;
  int   bad        = 0;
  int   acc_cnt    = 0;
  int   strobe_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a transfer
  always @(negedge clk) begin
    if (rstn && bus.psel && bus.penable) begin
      acc_cnt++;
      if (bus.pready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pready", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latency", 32'(acc_cnt), 32'(EXP_WAIT + 1));
          chk("pslverr", 32'(bus.pslverr), 32'(mon_e.err));
          if (!mon_e.wr) chk("prdata", 32'(bus.prdata), 32'(mon_e.data));
        end
        acc_cnt = 0;
      end else if (exp_q.size() != 0 && !exp_q[0].wr) begin
        chk("prdata_wait", 32'(bus.prdata), 32'(exp_q[0].data));
      end
    end else begin
      acc_cnt = 0;
    end
    if (rstn && wr_strobe) strobe_cnt++;
  end

  // Access-phase bus values are scrambled to prove only latched values matter
  task automatic xfer(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                      input logic [W-1:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    bit   done;
    e.wr = wr; e.data = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = wd;
    @(posedge clk); #1;
    bus.penable = 1'b1; bus.paddr = ~a; bus.pwdata = ~wd; bus.pwrite = ~wr;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (bus.pready) done = 1'b1;
      n++;
    end
    if (!done) begin
      chk("pready_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 8'h05; bus.pwdata = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",    32'(bus.pready),  32'd0);
    chk("rst_pslverr",   32'(bus.pslverr), 32'd0);
    chk("rst_prdata",    32'(bus.prdata),  32'd0);
    chk("rst_ctrl_out",  32'(ctrl_out),    32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe),   32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    rstn = 1'b1;
    idle(1);

    xfer(1'b0, 8'd0, 8'h00, 8'hA5, 1'b0);

    xfer(1'b1, 8'd5, 8'h3C, 8'h00, 1'b0);
    idle(1);
    chk("strobe_after_wr5", 32'(strobe_cnt), 32'd1);
    xfer(1'b0, 8'd5, 8'h00, 8'h3C, 1'b0);

    xfer(1'b1, 8'd1, 8'h81, 8'h00, 1'b0);
    chk("ctrl_out_81", 32'(ctrl_out), 32'h81);
    idle(1);
    chk("strobe_after_wr1", 32'(strobe_cnt), 32'd2);

    xfer(1'b1, 8'd0, 8'h55, 8'h00, 1'b1);
    idle(1);
    chk("strobe_after_err_wr", 32'(strobe_cnt), 32'd2);
    xfer(1'b0, 8'd0, 8'h00, 8'hA5, 1'b0);
    xfer(1'b0, 8'd16, 8'h00, 8'h00, 1'b1);

    xfer(1'b1, 8'd2, 8'h11, 8'h00, 1'b0);
    xfer(1'b0, 8'd2, 8'h00, 8'h11, 1'b0);
    xfer(1'b1, 8'd7, 8'hF0, 8'h00, 1'b0);
    xfer(1'b0, 8'd7, 8'h00, 8'hF0, 1'b0);
    idle(1);
    chk("strobe_after_b2b", 32'(strobe_cnt), 32'd4);
    chk("ctrl_out_hold", 32'(ctrl_out), 32'h81);

    // Abort a write to addr 3 with reset in its wait phase
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'd3; bus.pwdata = 8'h99;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    if (EXP_WAIT > 0) begin
      @(posedge clk); #1;
    end
    #1 rstn = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", 32'(bus.pready), 32'd0);
    chk("abort_ctrl_out", 32'(ctrl_out), 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    rstn = 1'b1;
    idle(2);
    chk("abort_no_strobe", 32'(strobe_cnt), 32'd4);
    xfer(1'b0, 8'd3, 8'h00, 8'h00, 1'b0);
    xfer(1'b0, 8'd1, 8'h00, 8'h00, 1'b0);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 10) begin
        idle(1);
        n++;
      end
    end
    chk("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates the bus driven by the team's APB master. It holds a small bank of WIDTH-bit registers and inserts a programmable number of wait states. It flags out-of-range and read-only-violation accesses with `pslverr`. Register 1 is exported as a control word to downstream logic.

## Interface
Parameters:
- `WIDTH`, 8: address and data width.
- `DEPTH`, 16: number of registers; legal addresses are 0..DEPTH-1; DEPTH ≤ 2^WIDTH.
- `WAIT_CYCLES`, 2: wait states per access, range 0..9. The APB master aborts after 10 consecutive low-`pready` cycles.
- `ID_VALUE`, 8'hA5: read-only contents of register 0.

Ports:
- `pclk` in 1: the single clock.
- `presetn` in 1: reset, asynchronous, active-low.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in WIDTH: register address.
- `pwdata` in WIDTH: write data.
- `prdata` out WIDTH: read data, registered.
- `pready` out 1: transfer complete, combinational.
- `pslverr` out 1: error response, valid only with `pready`.
- `ctrl_out` out WIDTH: current contents of register 1.
- `wr_strobe` out 1: one-cycle registered pulse after each committed write.

## Operation
- Setup phase is `psel & !penable`. On that edge the block:
  - latches `paddr`, `pwrite` and `pwdata`;
  - loads `wait_cnt` with WAIT_CYCLES;
  - for reads, loads `prdata` with: ID_VALUE if addr = 0; `mem[addr]` if addr is in range; 0 otherwise.
- Access phase is `psel & penable`.
  - `pready = access & (wait_cnt == 0)`.
  - While `wait_cnt != 0` during access, it decrements by 1 per cycle.
- Error condition: `pslverr = access & pready & err`, where `err` = latched addr ≥ DEPTH, or (write & addr = 0).
- Write commit happens on the edge where `access & pready & pwrite & !err`.
  - `mem[addr] <= pwdata_lat`.
  - `wr_strobe` is 1 for the following cycle.
- Errored accesses:
  - An errored write leaves the memory unchanged and produces no `wr_strobe`.
  - An errored read returns `prdata` = 0.
- Bus signal changes during the access phase (`paddr`, `pwrite`, `pwdata`) are ignored; only the latched values are used.
- Back-to-back transfers: a setup phase in the cycle immediately after a completed access is accepted normally.
- `psel` deasserted mid-access: `pready` drops and the counter freezes. A new setup phase reloads everything.
- Internal FSM:
  - IDLE → SETUP on `psel & !penable`.
  - SETUP → WAIT on access when WAIT_CYCLES > 0; SETUP → DONE when WAIT_CYCLES = 0.
  - WAIT → DONE when `wait_cnt` reaches 0.
  - DONE → SETUP if `psel & !penable`; DONE → IDLE otherwise.
  - Any state → IDLE on `!psel`.

## Timing
- Reset values (while `presetn` = 0): `prdata` = 0, `mem` = 0, `ctrl_out` = 0, `wr_strobe` = 0, `wait_cnt` = 0, FSM = IDLE.
- `pready` and `pslverr` are forced to 0 while `presetn` = 0, regardless of `psel`/`penable`.
- Latency: the first access-phase cycle plus WAIT_CYCLES. `pready` is high in the (WAIT_CYCLES+1)-th access cycle. With WAIT_CYCLES = 0, `pready` is high in the first access cycle.
- Read data is stable for the whole access phase.
- `ctrl_out` reflects a write to register 1 on the cycle after commit.
- Reset mid-transfer aborts the transfer; no write is committed.

## Configuration
- Macro: `APB_SLV_WAIT_EN`.
- Defined: wait-state counter present; behaviour exactly as above.
- Not defined:
  - Counter logic is removed and WAIT_CYCLES is ignored.
  - `pready = access`: zero wait states.
  - All error and commit rules are unchanged.

## Structure
- Shared package `apb_pkg` holds:
  - the FSM state enum (IDLE, SETUP, WAIT, DONE);
  - the address constants `ID_ADDR` = 0 and `CTRL_ADDR` = 1;
  - the `MAX_WAIT` = 9 limit.
- One sub-module: `apb_wait_counter`, which handles load, decrement and zero detect, and is compiled only under `APB_SLV_WAIT_EN`.
- The register array stays in the top module.

## Test plan
- Reset check: hold `presetn` low with `psel` = `penable` = 1. Required: `pready` = 0, `prdata` = 0, `ctrl_out` = 0. Then read addr 0. Required: `prdata` = 8'hA5, `pslverr` = 0.
- Write then read: write 8'h3C to addr 5, then read addr 5 with WAIT_CYCLES = 2. Required:
  - `pready` is high exactly in the 3rd access cycle;
  - `wr_strobe` pulses once;
  - the read returns 8'h3C.
- `ctrl_out`: write 8'h81 to addr 1. Required: `ctrl_out` = 8'h81 one cycle after the commit edge.
- Errors:
  - Write to addr 0 → `pslverr` = 1, register 0 still reads 8'hA5, no `wr_strobe`.
  - Read addr 16 (DEPTH = 16) → `pslverr` = 1, `prdata` = 0.
- Back-to-back plus mid-access reset:
  - Write addr 2 = 8'h11 immediately followed by read addr 2 → both complete and the read returns 8'h11.
  - Pulse `presetn` low during a WAIT-state write to addr 3 → addr 3 reads 0.
- Macro off: build without `APB_SLV_WAIT_EN` and write/read addr 7 = 8'hF0. Required: `pready` high in the first access cycle and the read returns 8'hF0.
